perf_counter_bank: RTL

Parametrised successor to the core's single free-running cycle counter. Provides NUM_CNT independent counters, each configurable to count cycles, event levels or event rising edges, with sticky overflow flags, an overflow interrupt, a global snapshot into shadow registers, and a CSR-style indexed read/write port. Sits beside the riscv_core CSR file, which maps rd/wr accesses onto mcycle/mhpmcounter-style addresses.

---
 rtl/perf_counter_pkg.sv | 26 ++
 rtl/perf_counter_channel.sv | 114 +++++++++++
 rtl/perf_counter_bank.sv | 99 +++++++++
 3 files changed

// File: rtl/perf_counter_pkg.sv
// Shared encodings for the performance counter bank: counting modes,
// access-select codes and bit positions inside the per-channel config word.
package perf_counter_pkg;

  typedef enum logic [1:0] {
    MODE_CYCLE = 2'd0,
    MODE_LEVEL = 2'd1,
    MODE_EDGE  = 2'd2,
    MODE_HOLD  = 2'd3
  } cnt_mode_e;

  localparam logic [1:0] WR_CNT     = 2'd0;
  localparam logic [1:0] WR_CFG     = 2'd1;
  localparam logic [1:0] WR_OVF_W1C = 2'd2;

  localparam logic [1:0] RD_CNT     = 2'd0;
  localparam logic [1:0] RD_CFG     = 2'd1;
  localparam logic [1:0] RD_OVF     = 2'd2;
  localparam logic [1:0] RD_SHADOW  = 2'd3;

  localparam int CFG_EN       = 0;
  localparam int CFG_MODE_LSB = 1;
  localparam int CFG_IRQ_EN   = 3;
  localparam int CFG_EVT_LSB  = 4;

endpackage

// File: rtl/perf_counter_channel.sv
// One counter channel: live counter, config, sticky overflow and snapshot shadow.
// The event line and its previous-cycle sample arrive from the shared history in the top.
module perf_counter_channel
  import perf_counter_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_EVT   = 8,
  parameter int EVT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 global_en_i,
  input  logic [NUM_EVT-1:0]   evt_i,
  input  logic [NUM_EVT-1:0]   evt_prev_i,
  input  logic                 snapshot_i,
  input  logic                 cnt_we_i,
  input  logic                 cfg_we_i,
  input  logic                 ovf_clr_i,
  input  logic [CNT_WIDTH-1:0] wr_data_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [CNT_WIDTH-1:0] cfg_o,
  output logic [CNT_WIDTH-1:0] shadow_o,
  output logic                 ovf_o,
  output logic                 irq_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
  logic                 en_q, en_d;
  cnt_mode_e            mode_q, mode_d;
  logic                 irqEn_q, irqEn_d;
  logic [EVT_W-1:0]     evtSel_q, evtSel_d;
  logic                 ovf_q, ovf_d;

  logic evtNow, evtPrev, modeHit, incEn, wrap;

  always_comb begin
    evtNow  = 1'b0;
    evtPrev = 1'b0;
    if (int'(evtSel_q) < NUM_EVT) begin
      evtNow  = evt_i[evtSel_q];
      evtPrev = evt_prev_i[evtSel_q];
    end

    case (mode_q)
      MODE_CYCLE: modeHit = 1'b1;
      MODE_LEVEL: modeHit = evtNow;
      MODE_EDGE:  modeHit = evtNow & ~evtPrev;
      default:    modeHit = 1'b0;
    endcase

    incEn = global_en_i & en_q & modeHit;
    // A software counter write suppresses both the increment and any wrap it would cause.
    wrap  = incEn & ~cnt_we_i & (&cnt_q);

    cnt_d = cnt_q;
    if (cnt_we_i) begin
      cnt_d = wr_data_i;
    end else if (incEn) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (wrap)      ovf_d = 1'b1;

    en_d     = en_q;
    mode_d   = mode_q;
    irqEn_d  = irqEn_q;
    evtSel_d = evtSel_q;
    if (cfg_we_i) begin
      en_d     = wr_data_i[CFG_EN];
      mode_d   = cnt_mode_e'(wr_data_i[CFG_MODE_LSB +: 2]);
      irqEn_d  = wr_data_i[CFG_IRQ_EN];
      evtSel_d = wr_data_i[CFG_EVT_LSB +: EVT_W];
    end

    shadow_d = snapshot_i ? cnt_q : shadow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      en_q     <= 1'b0;
      mode_q   <= MODE_CYCLE;
      irqEn_q  <= 1'b0;
      evtSel_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      irqEn_q  <= irqEn_d;
      evtSel_q <= evtSel_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    cfg_o                       = '0;
    cfg_o[CFG_EN]               = en_q;
    cfg_o[CFG_MODE_LSB +: 2]    = mode_q;
    cfg_o[CFG_IRQ_EN]           = irqEn_q;
    cfg_o[CFG_EVT_LSB +: EVT_W] = evtSel_q;
  end

  assign cnt_o    = cnt_q;
  assign shadow_o = shadow_q;
  assign ovf_o    = ovf_q;
  assign irq_o    = ovf_q & irqEn_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT performance counters with a CSR-style indexed access port.
// Holds the shared event history, write decode, read mux and registered read data.
module perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int  NUM_CNT   = 4,
  parameter int  CNT_WIDTH = 32,
  parameter int  NUM_EVT   = 8,
  localparam int IDX_W     = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  localparam int EVT_W     = $clog2(NUM_EVT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 global_en,
  input  logic [NUM_EVT-1:0]   evt_in,
  input  logic                 snapshot,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [1:0]           wr_sel,
  input  logic [CNT_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [IDX_W-1:0]     rd_idx,
  input  logic [1:0]           rd_sel,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic [NUM_CNT-1:0]   ovf,
  output logic                 irq
);

  logic [NUM_EVT-1:0]   evtPrev_q;
  logic [CNT_WIDTH-1:0] rdData_q;
  logic                 rdValid_q;

  logic [CNT_WIDTH-1:0] cntArr    [NUM_CNT];
  logic [CNT_WIDTH-1:0] cfgArr    [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadowArr [NUM_CNT];
  logic [NUM_CNT-1:0]   ovfVec;
  logic [NUM_CNT-1:0]   irqVec;
  logic [CNT_WIDTH-1:0] rdMux;

  // Indices past NUM_CNT match no channel, so writes to them simply vanish.
  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_ch
    logic hit;
    assign hit = wr_en && (wr_idx == IDX_W'(gi));

    perf_counter_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .NUM_EVT   (NUM_EVT),
      .EVT_W     (EVT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .global_en_i (global_en),
      .evt_i       (evt_in),
      .evt_prev_i  (evtPrev_q),
      .snapshot_i  (snapshot),
      .cnt_we_i    (hit && (wr_sel == WR_CNT)),
      .cfg_we_i    (hit && (wr_sel == WR_CFG)),
      .ovf_clr_i   (hit && (wr_sel == WR_OVF_W1C) && wr_data[0]),
      .wr_data_i   (wr_data),
      .cnt_o       (cntArr[gi]),
      .cfg_o       (cfgArr[gi]),
      .shadow_o    (shadowArr[gi]),
      .ovf_o       (ovfVec[gi]),
      .irq_o       (irqVec[gi])
    );
  end

  always_comb begin
    rdMux = '0;
    if (int'(rd_idx) < NUM_CNT) begin
      case (rd_sel)
        RD_CNT:    rdMux = cntArr[rd_idx];
        RD_CFG:    rdMux = cfgArr[rd_idx];
        RD_OVF:    rdMux = CNT_WIDTH'(ovfVec[rd_idx]);
        RD_SHADOW: rdMux = shadowArr[rd_idx];
        default:   rdMux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evtPrev_q <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      evtPrev_q <= evt_in;
      rdValid_q <= rd_en;
      if (rd_en) rdData_q <= rdMux;
    end
  end

  assign rd_data  = rdData_q;
  assign rd_valid = rdValid_q;
  assign ovf      = ovfVec;
  assign irq      = |irqVec;

endmodule
